// File: rtl/ice_frame_buffer_if.sv
// ----------------------------------------------------------------------------
// ice_frame_buffer_if
// Groups the frame-buffer side channels into one bundle:
//   - event-source byte stream: in_char, in_char_valid, in_char_last,
//     in_char_ready, in_overflow
//   - bus-controller slave read port: sl_addr, sl_data, sl_tail,
//     sl_latch_tail, sl_arb_request, frame_count
//   - optional drop statistics (ICE_FRAME_BUFFER_DROP_CNT_EN): drop_count,
//     drop_count_clr
// Modports:
//   master - the environment (event source + bus controller)
//   slave  - the frame buffer itself
// ----------------------------------------------------------------------------
interface ice_frame_buffer_if #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 8
);
  logic [7:0]        in_char;
  logic              in_char_valid;
  logic              in_char_last;
  logic              in_char_ready;
  logic              in_overflow;
  logic [ADDR_W-1:0] sl_addr;
  logic [8:0]        sl_data;
  logic [ADDR_W-1:0] sl_tail;
  logic              sl_latch_tail;
  logic              sl_arb_request;
  logic [CNT_W-1:0]  frame_count;
`ifdef ICE_FRAME_BUFFER_DROP_CNT_EN
  logic [7:0]        drop_count;
  logic              drop_count_clr;

  modport master (
    output in_char, in_char_valid, in_char_last, sl_addr, sl_latch_tail, drop_count_clr,
    input  in_char_ready, in_overflow, sl_data, sl_tail, sl_arb_request, frame_count, drop_count
  );
  modport slave (
    input  in_char, in_char_valid, in_char_last, sl_addr, sl_latch_tail, drop_count_clr,
    output in_char_ready, in_overflow, sl_data, sl_tail, sl_arb_request, frame_count, drop_count
  );
`else
  modport master (
    output in_char, in_char_valid, in_char_last, sl_addr, sl_latch_tail,
    input  in_char_ready, in_overflow, sl_data, sl_tail, sl_arb_request, frame_count
  );
  modport slave (
    input  in_char, in_char_valid, in_char_last, sl_addr, sl_latch_tail,
    output in_char_ready, in_overflow, sl_data, sl_tail, sl_arb_request, frame_count
  );
`endif
endinterface

// File: rtl/ice_frame_buffer.sv
// ----------------------------------------------------------------------------
// ice_frame_buffer
// Per-device circular frame store feeding the ICE bus controller's slave read
// port. Incoming byte frames get a reserved length slot inserted after the
// two header bytes; the final stored entry of a frame carries bit 8 = 1.
// Completed frames raise sl_arb_request; the controller reads by address and
// releases storage by latching a new tail.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-low reset
//   bus  - ice_frame_buffer_if.slave (byte stream in, slave read port out)
//
// Optional build macro: ICE_FRAME_BUFFER_DROP_CNT_EN adds a saturating
// drop_count of in_overflow pulses, cleared by drop_count_clr.
// ----------------------------------------------------------------------------
module ice_frame_buffer #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 8
) (
  input logic                clk,
  input logic                rst,
  ice_frame_buffer_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    W_HDR0 = 3'd0,
    W_HDR1 = 3'd1,
    W_LEN  = 3'd2,
    W_PYLD = 3'd3,
    W_DROP = 3'd4
  } wstate_e;

  logic [8:0]        mem_q [DEPTH];
  wstate_e           state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hdr_last_q, hdr_last_d;
  logic              ovf_q, ovf_d;
  logic [8:0]        sl_data_q;

  logic              we_s;
  logic [8:0]        wdata_s;
  logic              commit_s;
  logic              ready_s;
  logic              accept_s;
  logic              full_s;
  logic              latch_ok_s;
  logic [ADDR_W-1:0] wr_ptr_inc_s;

  assign wr_ptr_inc_s = wr_ptr_q + PTR_ONE;
  // One slot stays empty so that head == tail can mean "empty".
  assign full_s       = (wr_ptr_inc_s == tail_q);
  assign accept_s     = bus.in_char_valid & ready_s;
  // A release with nothing stored is ignored entirely (tail included).
  assign latch_ok_s   = bus.sl_latch_tail & (count_q != {CNT_W{1'b0}});

  // Ready decode: only the length slot stalls the source.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      W_HDR0, W_HDR1, W_PYLD, W_DROP: ready_s = 1'b1;
      W_LEN:                          ready_s = 1'b0;
      default:                        ready_s = 1'b0;
    endcase
  end

  // Write FSM next state, RAM write request, commit and overflow generation.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    head_d     = head_q;
    hdr_last_d = hdr_last_q;
    we_s       = 1'b0;
    wdata_s    = 9'h000;
    commit_s   = 1'b0;
    ovf_d      = 1'b0;
    case (state_q)
      W_HDR0: begin
        if (accept_s) begin
          if (bus.in_char_last) begin
            // A one-byte frame is malformed: drop it outright.
            wr_ptr_d = head_q;
            ovf_d    = 1'b1;
            state_d  = W_HDR0;
          end else if (full_s) begin
            wr_ptr_d = head_q;
            ovf_d    = 1'b1;
            state_d  = W_DROP;
          end else begin
            we_s     = 1'b1;
            wdata_s  = {1'b0, bus.in_char};
            wr_ptr_d = wr_ptr_inc_s;
            state_d  = W_HDR1;
          end
        end else begin
          state_d = W_HDR0;
        end
      end
      W_HDR1: begin
        if (accept_s) begin
          if (full_s) begin
            wr_ptr_d = head_q;
            ovf_d    = 1'b1;
            state_d  = bus.in_char_last ? W_HDR0 : W_DROP;
          end else begin
            we_s       = 1'b1;
            wdata_s    = {1'b0, bus.in_char};
            wr_ptr_d   = wr_ptr_inc_s;
            hdr_last_d = bus.in_char_last;
            state_d    = W_LEN;
          end
        end else begin
          state_d = W_HDR1;
        end
      end
      W_LEN: begin
        // Length slot carries the end-of-frame mark for header-only frames.
        if (full_s) begin
          wr_ptr_d = head_q;
          ovf_d    = 1'b1;
          state_d  = hdr_last_q ? W_HDR0 : W_DROP;
        end else begin
          we_s     = 1'b1;
          wdata_s  = {hdr_last_q, 8'h00};
          wr_ptr_d = wr_ptr_inc_s;
          if (hdr_last_q) begin
            commit_s = 1'b1;
            head_d   = wr_ptr_inc_s;
            state_d  = W_HDR0;
          end else begin
            state_d = W_PYLD;
          end
        end
      end
      W_PYLD: begin
        if (accept_s) begin
          if (full_s) begin
            wr_ptr_d = head_q;
            ovf_d    = 1'b1;
            state_d  = bus.in_char_last ? W_HDR0 : W_DROP;
          end else begin
            we_s     = 1'b1;
            wdata_s  = {bus.in_char_last, bus.in_char};
            wr_ptr_d = wr_ptr_inc_s;
            if (bus.in_char_last) begin
              commit_s = 1'b1;
              head_d   = wr_ptr_inc_s;
              state_d  = W_HDR0;
            end else begin
              state_d = W_PYLD;
            end
          end
        end else begin
          state_d = W_PYLD;
        end
      end
      W_DROP: begin
        if (accept_s && bus.in_char_last) begin
          state_d = W_HDR0;
        end else begin
          state_d = W_DROP;
        end
      end
      default: begin
        state_d  = W_HDR0;
        wr_ptr_d = head_q;
      end
    endcase
  end

  // Completed-frame counter and tail update; commit and release cancel out.
  always_comb begin
    count_d = count_q;
    tail_d  = latch_ok_s ? bus.sl_addr : tail_q;
    if (commit_s && latch_ok_s) begin
      count_d = count_q;
    end else if (commit_s) begin
      count_d = (count_q != CNT_MAX) ? (count_q + CNT_ONE) : count_q;
    end else if (latch_ok_s) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= W_HDR0;
      wr_ptr_q   <= {ADDR_W{1'b0}};
      head_q     <= {ADDR_W{1'b0}};
      tail_q     <= {ADDR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      hdr_last_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      hdr_last_q <= hdr_last_d;
      ovf_q      <= ovf_d;
    end
  end

  // Frame RAM write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sl_data_q <= 9'h000;
    end else begin
      sl_data_q <= mem_q[bus.sl_addr];
    end
  end

  assign bus.in_char_ready  = ready_s;
  assign bus.in_overflow    = ovf_q;
  assign bus.sl_data        = sl_data_q;
  assign bus.sl_tail        = tail_q;
  assign bus.frame_count    = count_q;
  assign bus.sl_arb_request = (count_q != {CNT_W{1'b0}});

`ifdef ICE_FRAME_BUFFER_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of overflow/malformed drops.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (bus.drop_count_clr) begin
      drop_cnt_d = 8'h00;
    end else if (ovf_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'h01;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.drop_count = drop_cnt_q;
`endif

endmodule
